sha256_block_controller: RTL and testbench

- Sequences one SHA-256 compression per 512-bit block over the existing message-schedule (w_file) and round datapath (main_loop).
- Loads the working registers, issues 64 round-advance strobes, then adds the final working state a..h into the running hash H0..H7 (mod 2^32 per word).
- Chains multi-block messages and presents the 256-bit digest, with a start/busy/done handshake, to the top level or the software I/O path.

---
 rtl/sha256_block_controller.sv | 150 +++++++++++++++
 tb/tb_sha256_block_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_controller.sv
// SHA-256 block controller: sequences one compression per 512-bit block
// over the message-schedule and round datapath, chains blocks into the
// running hash H0..H7, and presents the digest with a start/busy/done
// handshake. All outputs come straight from flops.
module sha256_block_controller #(
    parameter int unsigned  ROUNDS = 64,
    parameter logic [255:0] IV     = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         start,
    input  logic         first_block,
    input  logic         last_block,
    input  logic [255:0] work_in,
    output logic         init,
    output logic         next,
    output logic [5:0]   round,
    output logic [255:0] h_state,
    output logic         busy,
    output logic         block_done,
    output logic [255:0] digest,
    output logic         digest_valid
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_ROUND  = 3'd2;
    localparam logic [2:0] ST_UPDATE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    // Eight independent 32-bit adds; carries never cross word boundaries.
    function automatic logic [255:0] add_words(input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        r = 256'd0;
        for (int i = 0; i < 8; i++) begin
            r[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32];
        end
        return r;
    endfunction

    logic [2:0]   state_q, state_d;
    logic [5:0]   round_q, round_d;
    logic [255:0] h_q, h_d;
    logic         last_q, last_d;
    logic         dv_q, dv_d;
    logic         init_q, init_d;
    logic         next_q, next_d;
    logic         busy_q, busy_d;
    logic         block_done_q, block_done_d;

    // Next-state, round counter, hash update and latched-flag logic.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        h_d     = h_q;
        last_d  = last_q;
        dv_d    = dv_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_INIT;
                    last_d  = last_block;
                    dv_d    = 1'b0;
                    round_d = 6'd0;
                    if (first_block) begin
                        h_d = IV;
                    end else begin
                        h_d = h_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                state_d = ST_ROUND;
                round_d = 6'd0;
            end
            ST_ROUND: begin
                if (round_q == LAST_ROUND) begin
                    state_d = ST_UPDATE;
                    round_d = 6'd0;
                end else begin
                    round_d = round_q + 6'd1;
                end
            end
            ST_UPDATE: begin
                h_d     = add_words(h_q, work_in);
                state_d = ST_DONE;
                if (last_q) begin
                    dv_d = 1'b1;
                end else begin
                    dv_d = dv_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                round_d = 6'd0;
            end
        endcase
    end

    // Strobes are decoded from the next state so they can be registered
    // and still line up with the state they belong to.
    always_comb begin
        init_d       = (state_d == ST_INIT);
        next_d       = (state_d == ST_ROUND);
        busy_d       = (state_d != ST_IDLE);
        block_done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            round_q      <= 6'd0;
            h_q          <= IV;
            last_q       <= 1'b0;
            dv_q         <= 1'b0;
            init_q       <= 1'b0;
            next_q       <= 1'b0;
            busy_q       <= 1'b0;
            block_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            h_q          <= h_d;
            last_q       <= last_d;
            dv_q         <= dv_d;
            init_q       <= init_d;
            next_q       <= next_d;
            busy_q       <= busy_d;
            block_done_q <= block_done_d;
        end
    end

    assign init         = init_q;
    assign next         = next_q;
    assign round        = round_q;
    assign h_state      = h_q;
    assign digest       = h_q;
    assign busy         = busy_q;
    assign block_done   = block_done_q;
    assign digest_valid = dv_q;

endmodule

// File: tb/tb_sha256_block_controller.sv
// Self-checking bench for sha256_block_controller. Block-level vectors
// come from a table; expected digests are queued when a block is started
// and popped when block_done appears. Cycle 0 is the cycle in which start
// is presented; the accept edge closes it.
module tb_sha256_block_controller;

    localparam logic [255:0] IV_C   = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ONES_C = 256'h00000001_00000001_00000001_00000001_00000001_00000001_00000001_00000001;
    localparam logic [255:0] IVP1_C = 256'h6a09e668_bb67ae86_3c6ef373_a54ff53b_510e5280_9b05688d_1f83d9ac_5be0cd1a;
    localparam logic [255:0] IVP2_C = 256'h6a09e669_bb67ae87_3c6ef374_a54ff53c_510e5281_9b05688e_1f83d9ad_5be0cd1b;
    localparam logic [255:0] ABC_C  = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] ALLF_C = {256{1'b1}};

    logic         clk;
    logic         Reset;
    logic         start;
    logic         first_block;
    logic         last_block;
    logic [255:0] work_in;
    logic         init_o;
    logic         next_o;
    logic [5:0]   round_o;
    logic [255:0] h_state_o;
    logic         busy_o;
    logic         block_done_o;
    logic [255:0] digest_o;
    logic         digest_valid_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         first;
        logic         last;
        logic [255:0] work;
        logic         pulse;
        logic [255:0] exp_digest;
        logic         exp_valid;
    } vec_t;

    typedef struct {
        logic [255:0] d;
        logic         v;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];

    sha256_block_controller dut (
        .clk          (clk),
        .Reset        (Reset),
        .start        (start),
        .first_block  (first_block),
        .last_block   (last_block),
        .work_in      (work_in),
        .init         (init_o),
        .next         (next_o),
        .round        (round_o),
        .h_state      (h_state_o),
        .busy         (busy_o),
        .block_done   (block_done_o),
        .digest       (digest_o),
        .digest_valid (digest_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Per-word modular subtraction, used to build work_in from a target digest.
    function automatic logic [255:0] sub_words(input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        r = 256'd0;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = a[i*32 +: 32] - b[i*32 +: 32];
        return r;
    endfunction

    task automatic run_block(input vec_t v, input string tag);
        int   seq_bad;
        int   done_cnt;
        exp_t e;
        logic [9:0] act_s;
        logic [9:0] exp_s;
        seq_bad  = 0;
        done_cnt = 0;
        @(negedge clk);
        first_block = v.first;
        last_block  = v.last;
        work_in     = v.work;
        start       = 1'b1;
        sb.push_back('{d: v.exp_digest, v: v.exp_valid});
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            start       = 1'b0;
            first_block = 1'b0;
            last_block  = 1'b0;
            if (c == 1) chk({tag, "_dv_clear"}, {255'd0, digest_valid_o}, 256'd0);
            exp_s = {(c == 1), (c >= 2 && c <= 65),
                     ((c >= 2 && c <= 65) ? 6'(c - 2) : 6'd0),
                     (c >= 1 && c <= 67), (c == 67)};
            act_s = {init_o, next_o, round_o, busy_o, block_done_o};
            if (act_s !== exp_s) seq_bad++;
            if (block_done_o === 1'b1) done_cnt++;
            if (c == 67) begin
                chk({tag, "_sb_size"}, 256'(sb.size()), 256'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk({tag, "_digest"}, digest_o, e.d);
                    chk({tag, "_h_state"}, h_state_o, e.d);
                    chk({tag, "_valid"}, {255'd0, digest_valid_o}, {255'd0, e.v});
                end
            end
            // Stray starts in ROUND (round=10) and UPDATE must be ignored.
            if (v.pulse && (c == 12 || c == 66)) begin
                start       = 1'b1;
                first_block = 1'b1;
                last_block  = 1'b0;
            end
        end
        chk({tag, "_timing_errs"}, 256'(seq_bad), 256'd0);
        chk({tag, "_done_cnt"}, 256'(done_cnt), 256'd1);
    endtask

    initial begin
        string tag;
        vecs[0] = '{first: 1'b1, last: 1'b1, work: 256'd0, pulse: 1'b0, exp_digest: IV_C, exp_valid: 1'b1};
        vecs[1] = '{first: 1'b1, last: 1'b1, work: ONES_C, pulse: 1'b0, exp_digest: IVP1_C, exp_valid: 1'b1};
        vecs[2] = '{first: 1'b1, last: 1'b0, work: ~IV_C, pulse: 1'b0, exp_digest: ALLF_C, exp_valid: 1'b0};
        vecs[3] = '{first: 1'b0, last: 1'b1, work: ONES_C, pulse: 1'b0, exp_digest: 256'd0, exp_valid: 1'b1};
        vecs[4] = '{first: 1'b1, last: 1'b0, work: ONES_C, pulse: 1'b0, exp_digest: IVP1_C, exp_valid: 1'b0};
        vecs[5] = '{first: 1'b0, last: 1'b1, work: ONES_C, pulse: 1'b1, exp_digest: IVP2_C, exp_valid: 1'b1};
        vecs[6] = '{first: 1'b1, last: 1'b1, work: sub_words(ABC_C, IV_C), pulse: 1'b0, exp_digest: ABC_C, exp_valid: 1'b1};
        vecs[7] = '{first: 1'b0, last: 1'b1, work: 256'd0, pulse: 1'b0, exp_digest: ABC_C, exp_valid: 1'b1};

        Reset       = 1'b1;
        start       = 1'b0;
        first_block = 1'b0;
        last_block  = 1'b0;
        work_in     = 256'd0;
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
        chk("rst_digest", digest_o, IV_C);
        chk("rst_ctrl", {246'd0, init_o, next_o, round_o, busy_o, block_done_o},
            256'd0);
        chk("rst_valid", {255'd0, digest_valid_o}, 256'd0);

        for (int i = 0; i < 8; i++) begin
            tag = $sformatf("blk%0d", i);
            run_block(vecs[i], tag);
        end

        // Chained block aborted by Reset at round 30, with start held in the same cycle.
        @(negedge clk);
        first_block = 1'b0;
        last_block  = 1'b1;
        work_in     = ONES_C;
        start       = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("abort_round", {250'd0, round_o}, 256'd30);
        Reset       = 1'b1;
        start       = 1'b1;
        first_block = 1'b1;
        @(negedge clk);
        Reset       = 1'b0;
        start       = 1'b0;
        first_block = 1'b0;
        chk("abort_ctrl", {246'd0, init_o, next_o, round_o, busy_o, block_done_o},
            256'd0);
        chk("abort_h", h_state_o, IV_C);
        chk("abort_valid", {255'd0, digest_valid_o}, 256'd0);
        @(negedge clk);
        chk("abort_start_dropped", {255'd0, busy_o}, 256'd0);

        run_block(vecs[0], "post_abort");
        chk("sb_drained", 256'(sb.size()), 256'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
